// File: rtl/serdes_pkg.sv
// Shared definitions for the secure SERDES link (encryptor and decryptor).
//   state_t      : receive FSM states
//   SERDES_WIDTH : default word width used by both ends of the link
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SERDES_WIDTH = 8;

endpackage

// File: rtl/serdes_shift_in.sv
// Dual MSB-first deserializer for the cipher and key streams, plus the
// frame bit counter.
// Ports:
//   clk, rst       : clock, async active-high reset
//   load           : frame start accepted; counter loads WIDTH-1
//   en             : a data bit is sampled this cycle
//   c_bit, k_bit   : serial cipher / key bits
//   c_next, k_next : shift register contents including this cycle's bit
//   last           : this cycle samples the final (LSB) bit of the frame
module serdes_shift_in
    import serdes_pkg::*;
#(
    parameter int WIDTH = SERDES_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             c_bit,
    input  logic             k_bit,
    output logic [WIDTH-1:0] c_next,
    output logic [WIDTH-1:0] k_next,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] cshift;
    logic [WIDTH-1:0] kshift;
    logic [CW-1:0]    cnt;

    // The completing word is taken from the next-state value so the final
    // bit is included without waiting an extra cycle.
    assign c_next = {cshift[WIDTH-2:0], c_bit};
    assign k_next = {kshift[WIDTH-2:0], k_bit};
    assign last   = en && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cshift <= '0;
            kshift <= '0;
            cnt    <= '0;
        end else begin
            if (load)
                cnt <= CW'(WIDTH - 1);
            else if (en && !last)
                cnt <= cnt - 1'b1;
            if (en) begin
                cshift <= c_next;
                kshift <= k_next;
            end
        end
    end

endmodule

// File: rtl/serdes_decryptor_rx.sv
// Receive side of the secure SERDES link: deserializes cipher and key
// streams after a start strobe, recovers plain = cipher ^ key and holds it
// in a valid/ready output register.
// Ports:
//   clk, rst     : clock, async active-high reset
//   start        : frame start strobe (honoured only when idle)
//   c_bit, k_bit : serial cipher / key bits, MSB first, aligned
//   plain        : recovered word, stable while plain_valid=1
//   plain_valid  : plain holds an unconsumed word
//   plain_ready  : consumer accepts when valid & ready
//   busy         : frame being shifted in
//   overrun      : sticky, a completed word was dropped (cleared by rst)
module serdes_decryptor_rx
    import serdes_pkg::*;
#(
    parameter int WIDTH = SERDES_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             c_bit,
    input  logic             k_bit,
    output logic [WIDTH-1:0] plain,
    output logic             plain_valid,
    input  logic             plain_ready,
    output logic             busy,
    output logic             overrun
);

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             en;
    logic             last;
    logic [WIDTH-1:0] c_next;
    logic [WIDTH-1:0] k_next;

    assign en   = (state_q == SHIFT);
    assign busy = en;

    serdes_shift_in #(.WIDTH(WIDTH)) u_shift_in (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .en     (en),
        .c_bit  (c_bit),
        .k_bit  (k_bit),
        .c_next (c_next),
        .k_next (k_next),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // start is only looked at in IDLE, so a strobe during the frame
    // (including its final bit) is dropped.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A completing word may replace the held one only when that one is
    // being consumed on the same edge; otherwise it is lost and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plain       <= '0;
            plain_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (last) begin
            if (!plain_valid || plain_ready) begin
                plain       <= c_next ^ k_next;
                plain_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (plain_valid && plain_ready) begin
            plain_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serdes_decryptor_rx.sv
module tb_serdes_decryptor_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         c_bit = 1'b0;
    logic         k_bit = 1'b0;
    logic         plain_ready = 1'b0;
    logic [W-1:0] plain;
    logic         plain_valid;
    logic         busy;
    logic         overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame-level view of the receiver.
    bit           m_busy, m_valid, m_over;
    int           m_n;
    logic [W-1:0] m_c, m_k, m_plain;

    serdes_decryptor_rx #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .c_bit       (c_bit),
        .k_bit       (k_bit),
        .plain       (plain),
        .plain_valid (plain_valid),
        .plain_ready (plain_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_busy = 0; m_valid = 0; m_over = 0; m_n = 0;
        m_c = '0; m_k = '0; m_plain = '0;
    endtask

    // One clock: drive at negedge, advance model at posedge, settle 1 unit.
    task automatic step(input logic s, input logic c, input logic k, input logic r);
        bit done;
        @(negedge clk);
        start = s; c_bit = c; k_bit = k; plain_ready = r;
        @(posedge clk);
        done = 0;
        if (!m_busy) begin
            if (s) begin
                m_busy = 1; m_n = 0;
            end
        end else begin
            m_c = {m_c[W-2:0], c};
            m_k = {m_k[W-2:0], k};
            m_n++;
            if (m_n == W) begin
                done = 1; m_busy = 0;
            end
        end
        if (done) begin
            if (!m_valid || r) begin
                m_plain = m_c ^ m_k; m_valid = 1;
            end else begin
                m_over = 1;
            end
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] c, input logic [W-1:0] k, input logic r);
        step(1'b1, 1'b0, 1'b0, r);
        for (int i = W - 1; i >= 0; i--) step(1'b0, c[i], k[i], r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; plain_ready = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (plain !== '0 || plain_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: plain=%h valid=%b busy=%b ovr=%b, want 0/0/0/0",
                     plain, plain_valid, busy, overrun);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int bc;
        do_reset();
        bc = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        if (busy) bc++;
        for (int i = W - 1; i >= 0; i--) begin
            if (i == 0) begin
                n_tests++;
                if (plain_valid !== 1'b0) begin
                    n_fail++; $display("FAIL single_early: valid=%b want 0 at edge 8", plain_valid);
                end
            end
            step(1'b0, 1'(8'h01 >> i), 1'(8'h03 >> i), 1'b1);
            if (busy) bc++;
        end
        n_tests++;
        if (plain !== 8'h02 || plain_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL single_word: plain=%h valid=%b ovr=%b, want 02/1/0", plain, plain_valid, overrun);
        end
        n_tests++;
        if (bc != W) begin
            n_fail++; $display("FAIL single_busy: busy cycles=%0d want %0d", bc, W);
        end
    endtask

    task automatic test_stall();
        int bad;
        do_reset();
        send_frame(8'hC3, 8'h5A, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (plain !== 8'h99 || plain_valid !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL stall_hold: plain=%h valid=%b, want 99/1 (%0d bad cycles)", plain, plain_valid, bad);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (plain_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_accept: valid=%b want 0", plain_valid);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(8'hFF, 8'h0F, 1'b0);
        send_frame(8'h00, 8'hAA, 1'b0);
        n_tests++;
        if (plain !== 8'hF0 || plain_valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: plain=%h valid=%b ovr=%b, want f0/1/1", plain, plain_valid, overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (plain_valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL overrun_sticky: valid=%b ovr=%b, want 0/1", plain_valid, overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] c1, k1, c2, k2;
        int bad;
        do_reset();
        c1 = W'($urandom); k1 = W'($urandom); c2 = W'($urandom); k2 = W'($urandom);
        send_frame(c1, k1, 1'b0);
        n_tests++;
        if (plain !== (c1 ^ k1) || plain_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: plain=%h valid=%b want %h/1", plain, plain_valid, c1 ^ k1);
        end
        bad = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b0, c2[i], k2[i], (i == 0));
            if (plain_valid !== 1'b1) bad++;
        end
        n_tests++;
        if (plain !== (c2 ^ k2) || bad != 0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_swap: plain=%h want %h, valid drops=%0d, ovr=%b", plain, c2 ^ k2, bad, overrun);
        end
    endtask

    task automatic test_framing();
        logic [W-1:0] c1, k1, c2, k2;
        do_reset();
        c1 = W'($urandom); k1 = W'($urandom); c2 = W'($urandom); k2 = W'($urandom);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = W - 1; i >= 0; i--) step((i == W - 4), c1[i], k1[i], 1'b0);
        n_tests++;
        if (plain !== (c1 ^ k1) || plain_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midstart: plain=%h valid=%b busy=%b want %h/1/0", plain, plain_valid, busy, c1 ^ k1);
        end
        // Next start immediately after the last bit; consuming the first word.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = W - 1; i >= 0; i--) begin
            if (i == 0) begin
                n_tests++;
                if (plain_valid !== 1'b0) begin
                    n_fail++; $display("FAIL next_early: valid=%b want 0", plain_valid);
                end
            end
            step(1'b0, c2[i], k2[i], 1'b1);
        end
        n_tests++;
        if (plain !== (c2 ^ k2) || plain_valid !== 1'b1) begin
            n_fail++; $display("FAIL next_frame: plain=%h valid=%b want %h/1", plain, plain_valid, c2 ^ k2);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] c, k;
        do_reset();
        send_frame(8'h5A, 8'h33, 1'b0);
        send_frame(8'h11, 8'h22, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || plain_valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: busy=%b valid=%b ovr=%b want 1/1/1", busy, plain_valid, overrun);
        end
        #2 rst = 1'b1;
        model_clear();
        #1;
        n_tests++;
        if (plain !== '0 || plain_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: plain=%h valid=%b busy=%b ovr=%b want all 0", plain, plain_valid, busy, overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        c = W'($urandom); k = W'($urandom);
        send_frame(c, k, 1'b0);
        n_tests++;
        if (plain !== (c ^ k) || plain_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after: plain=%h valid=%b ovr=%b want %h/1/0", plain, plain_valid, overrun, c ^ k);
        end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int f = 0; f < 60; f++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            for (int i = 0; i < W; i++) begin
                step(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
                n_tests++;
                if (plain !== m_plain || plain_valid !== m_valid || busy !== m_busy || overrun !== m_over) begin
                    n_fail++;
                    if (bad < 10)
                        $display("FAIL random f%0d: plain=%h valid=%b busy=%b ovr=%b want %h/%b/%b/%b",
                                 f, plain, plain_valid, busy, overrun, m_plain, m_valid, m_busy, m_over);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_framing();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_decryptor_rx.md
# serdes_decryptor_rx

Receive-side counterpart of the secure SERDES encryptor. It deserializes an MSB-first cipher bit stream and its matching key bit stream, framed by a one-cycle start pulse. It then recovers the plaintext word as cipher XOR key and presents it on a valid/ready output register. The block sits at the far end of the serial link, between the link pins and the consuming logic.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame start strobe; sampled only in IDLE.
- c_bit  in  1  serial cipher bit, MSB first.
- k_bit  in  1  serial key bit, MSB first, aligned with c_bit.
- plain  out  WIDTH  recovered plaintext word; held stable while plain_valid=1.
- plain_valid  out  1  plain holds an unconsumed word.
- plain_ready  in  1  consumer accepts the word on any edge where valid&ready=1.
- busy  out  1  high while a frame is being shifted in (state SHIFT).
- overrun  out  1  sticky flag: a completed word was dropped; cleared only by rst.

## Operation
- Reset values: plain=0, plain_valid=0, busy=0, overrun=0, state=IDLE, bit counter=0, shift registers=0.
- State IDLE:
  - If start=1 at an edge, go to SHIFT and load the counter with WIDTH-1.
  - c_bit and k_bit are ignored in IDLE.
- State SHIFT:
  - Each edge: cshift <= {cshift[WIDTH-2:0], c_bit} and kshift <= {kshift[WIDTH-2:0], k_bit}. The counter decrements.
  - On the edge where the counter is 0 (WIDTH-th sample), the word completes using the just-sampled bits, and the state returns to IDLE.
  - start is ignored throughout SHIFT, including the final-bit cycle.
- Word completion: the candidate word is (cshift_next XOR kshift_next), a bitwise XOR of WIDTH bits with no carry. Resolve it as follows:
  - plain_valid=0: load plain with the word and set plain_valid=1.
  - plain_valid=1 and plain_ready=1 on the same edge: the old word is consumed, the new word loads, and plain_valid stays 1.
  - plain_valid=1 and plain_ready=0: drop the new word, keep plain unchanged, and set overrun=1.
- Output handshake:
  - An edge with plain_valid=1 and plain_ready=1 and no completion clears plain_valid.
  - plain_ready while plain_valid=0 has no effect.
  - plain must not change while plain_valid=1 unless a transfer occurs on that edge.
- Reset mid-frame: rst asserted asynchronously aborts the frame, discards partial bits, and returns all outputs to their reset values.

## Timing
- The start strobe is sampled at edge t0. Data bits MSB..LSB are sampled at edges t1..tWIDTH, one per cycle, with no gaps.
- plain_valid rises after edge tWIDTH, so the first plaintext is visible WIDTH+1 edges after start.
- busy is high from after t0 through edge tWIDTH, and low after tWIDTH.
- Back-to-back frames: the next start may be asserted in the cycle immediately after tWIDTH. Minimum frame period is WIDTH+1 cycles.
- No combinational path from any input to any output. All outputs are registered.

## Structure
- Shared package serdes_pkg holds:
  - the state enum {IDLE, SHIFT};
  - the default word width constant SERDES_WIDTH=8, also used by the encryptor.
- One natural sub-module, serdes_shift_in. It contains the dual MSB-first shift register and the down-counter, and outputs a single-cycle `last` flag.
- The top level holds the FSM, the XOR, the output register/handshake and the overrun flag.

## Test plan
- Single frame, WIDTH=8: start pulse, then c=0x01 and k=0x03 MSB first, with plain_ready=1.
  - Required: plain=0x02 and plain_valid=1 exactly 9 edges after start; busy high for 8 cycles; overrun=0.
- Consumer stall: frame c=0xC3, k=0x5A with plain_ready=0.
  - Required: plain=0x99 held and valid held for 20 cycles.
  - Then ready=1 for one edge: valid drops.
- Overrun: two back-to-back frames, c=0xFF,k=0x0F then c=0x00,k=0xAA, with ready=0 throughout.
  - Required: plain stays 0xF0 and overrun=1 after the second completion.
  - When ready is later pulsed: valid clears and overrun remains 1.
- Simultaneous completion and accept: ready=1 on the completion edge of the second of two back-to-back frames.
  - Required: plain switches to the second word with valid continuously 1.
- Framing rules:
  - start pulsed mid-frame (bit 4) is ignored, and the word is correct.
  - start asserted the cycle after the last bit begins a new frame, and the second word arrives 9 edges later.
- Reset mid-frame: assert rst after 4 bits.
  - Required: all outputs are 0 immediately (asynchronously).
  - A new full frame afterwards decodes correctly with no residue.
